// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch lap recorder: state encoding and state type.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

endpackage

// File: rtl/lap_ram.sv
// Lap storage: one synchronous write port plus one registered read port that
// returns the old contents when reading the entry being written.
module lap_ram #(
   parameter int CNT_W  = 8,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [CNT_W-1:0]  wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_zero,
   output logic [CNT_W-1:0]  rd_data
);

   logic [CNT_W-1:0] mem [DEPTH];
   logic [CNT_W-1:0] rd_data_q;
   logic [CNT_W-1:0] rd_data_d;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // rd_zero masks entries that are not logically valid; the register holds otherwise.
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = rd_zero ? '0 : mem[rd_addr];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/stopwatch_lap_recorder.sv
// Stopwatch with prescaled unit counter, IDLE/RUN/PAUSE control and a lap buffer
// with registered read port.
module stopwatch_lap_recorder
   import stopwatch_pkg::*;
#(
   parameter int CLK_DIV = 50_000_000,
   parameter int CNT_W   = 8,
   parameter int DEPTH   = 8,
   parameter int ADDR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              pause,
   input  logic              clear,
   input  logic              lap,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [CNT_W-1:0]  rd_data,
   output logic              rd_valid,
   output logic              tick,
   output logic [CNT_W-1:0]  unit_count,
   output logic [1:0]        state,
   output logic [ADDR_W:0]   lap_count,
   output logic              lap_full,
   output logic              lap_drop,
   output logic              overflow
);

   localparam int PW = $clog2(CLK_DIV);
   localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_DIV - 1);
   localparam logic [ADDR_W:0] LAPS_MAX   = (ADDR_W + 1)'(DEPTH);

   state_t            state_q, state_d;
   logic [PW-1:0]     presc_q, presc_d;
   logic [CNT_W-1:0]  unit_q, unit_d;
   logic [ADDR_W:0]   lap_count_q, lap_count_d;
   logic              lap_full_q, lap_full_d;
   logic              lap_drop_q, lap_drop_d;
   logic              overflow_q, overflow_d;
   logic              tick_q, tick_d;
   logic              rd_valid_q, rd_valid_d;
   logic              lap_we;
   logic              rd_zero;

   always_comb begin
      state_d     = state_q;
      presc_d     = presc_q;
      unit_d      = unit_q;
      lap_count_d = lap_count_q;
      lap_drop_d  = lap_drop_q;
      overflow_d  = overflow_q;
      tick_d      = 1'b0;
      lap_we      = 1'b0;
      rd_valid_d  = rd_en;

      if (clear) begin
         state_d     = ST_IDLE;
         presc_d     = '0;
         unit_d      = '0;
         lap_count_d = '0;
         lap_drop_d  = 1'b0;
         overflow_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               presc_d = '0;
               unit_d  = '0;
               if (start) begin
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               if (presc_q == PRESC_LAST) begin
                  presc_d = '0;
                  tick_d  = 1'b1;
                  unit_d  = unit_q + CNT_W'(1);
                  if (&unit_q) begin
                     overflow_d = 1'b1;
                  end
               end else begin
                  presc_d = presc_q + PW'(1);
               end
               // The lap records unit_q, i.e. the value before any coincident tick.
               if (lap) begin
                  if (lap_count_q == LAPS_MAX) begin
                     lap_drop_d = 1'b1;
                  end else begin
                     lap_we      = 1'b1;
                     lap_count_d = lap_count_q + (ADDR_W + 1)'(1);
                  end
               end
               if (pause) begin
                  state_d = ST_PAUSE;
               end
            end
            ST_PAUSE: begin
               if (start) begin
                  state_d = ST_RUN;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      lap_full_d = (lap_count_d == LAPS_MAX);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         presc_q     <= '0;
         unit_q      <= '0;
         lap_count_q <= '0;
         lap_full_q  <= 1'b0;
         lap_drop_q  <= 1'b0;
         overflow_q  <= 1'b0;
         tick_q      <= 1'b0;
         rd_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         unit_q      <= unit_d;
         lap_count_q <= lap_count_d;
         lap_full_q  <= lap_full_d;
         lap_drop_q  <= lap_drop_d;
         overflow_q  <= overflow_d;
         tick_q      <= tick_d;
         rd_valid_q  <= rd_valid_d;
      end
   end

   // Entries at or beyond lap_count are stale after a clear and read back as zero.
   assign rd_zero = ({1'b0, rd_addr} >= lap_count_q);

   lap_ram #(
      .CNT_W  (CNT_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_lap_ram (
      .clk     (clk),
      .rst     (rst),
      .we      (lap_we),
      .wr_addr (lap_count_q[ADDR_W-1:0]),
      .wr_data (unit_q),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_zero (rd_zero),
      .rd_data (rd_data)
   );

   assign rd_valid   = rd_valid_q;
   assign tick       = tick_q;
   assign unit_count = unit_q;
   assign state      = state_q;
   assign lap_count  = lap_count_q;
   assign lap_full   = lap_full_q;
   assign lap_drop   = lap_drop_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_stopwatch_lap_recorder.sv
// Self-checking bench: elapsed-cycle reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_stopwatch_lap_recorder;

   localparam int CLK_DIV = 4;
   localparam int CNT_W   = 4;
   localparam int DEPTH   = 4;
   localparam int ADDR_W  = 2;

   localparam int P_START = 0;
   localparam int P_PAUSE = 1;
   localparam int P_CLEAR = 2;
   localparam int P_LAP   = 3;

   logic              clk     = 1'b0;
   logic              rst     = 1'b1;
   logic              start   = 1'b0;
   logic              pause   = 1'b0;
   logic              clear   = 1'b0;
   logic              lap     = 1'b0;
   logic              rd_en   = 1'b0;
   logic [ADDR_W-1:0] rd_addr = '0;
   logic [CNT_W-1:0]  rd_data;
   logic              rd_valid;
   logic              tick;
   logic [CNT_W-1:0]  unit_count;
   logic [1:0]        state;
   logic [ADDR_W:0]   lap_count;
   logic              lap_full;
   logic              lap_drop;
   logic              overflow;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   stopwatch_lap_recorder #(
      .CLK_DIV (CLK_DIV),
      .CNT_W   (CNT_W),
      .DEPTH   (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .pause      (pause),
      .clear      (clear),
      .lap        (lap),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .tick       (tick),
      .unit_count (unit_count),
      .state      (state),
      .lap_count  (lap_count),
      .lap_full   (lap_full),
      .lap_drop   (lap_drop),
      .overflow   (overflow)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
      $display("  t=%0t %s = %0d (expect %0d)", $time, name, act, exp);
      chk(name, act, exp);
   endtask

   // Reference model: the whole timing state is the count of clock cycles spent in RUN.
   int m_state = 0;
   int m_run   = 0;
   int m_nlaps = 0;
   int m_drop  = 0;
   int m_tick  = 0;
   int m_rdv   = 0;
   int m_rdd   = 0;
   int m_cur   = 0;
   int m_laps [DEPTH];

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_state = 0; m_run = 0; m_nlaps = 0; m_drop = 0;
            m_tick  = 0; m_rdv = 0; m_rdd = 0;
         end else begin
            m_cur = (m_run / CLK_DIV) % (1 << CNT_W);
            m_rdv = rd_en ? 1 : 0;
            if (rd_en) m_rdd = (int'(rd_addr) < m_nlaps) ? m_laps[rd_addr] : 0;
            m_tick = 0;
            if (clear) begin
               m_state = 0; m_run = 0; m_nlaps = 0; m_drop = 0;
            end else if (m_state == 0) begin
               if (start) m_state = 1;
            end else if (m_state == 1) begin
               if (lap) begin
                  if (m_nlaps == DEPTH) m_drop = 1;
                  else begin
                     m_laps[m_nlaps] = m_cur;
                     m_nlaps++;
                  end
               end
               m_run++;
               m_tick = (m_run % CLK_DIV == 0) ? 1 : 0;
               if (pause) m_state = 2;
            end else begin
               if (start) m_state = 1;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("state",      32'(state),      m_state);
            chk("unit_count", 32'(unit_count), (m_run / CLK_DIV) % (1 << CNT_W));
            chk("overflow",   32'(overflow),   ((m_run / CLK_DIV) >= (1 << CNT_W)) ? 1 : 0);
            chk("tick",       32'(tick),       m_tick);
            chk("lap_count",  32'(lap_count),  m_nlaps);
            chk("lap_full",   32'(lap_full),   (m_nlaps == DEPTH) ? 1 : 0);
            chk("lap_drop",   32'(lap_drop),   m_drop);
            chk("rd_valid",   32'(rd_valid),   m_rdv);
            chk("rd_data",    32'(rd_data),    m_rdd);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input int which);
      case (which)
         P_START: start = 1'b1;
         P_PAUSE: pause = 1'b1;
         P_CLEAR: clear = 1'b1;
         default: lap   = 1'b1;
      endcase
      @(negedge clk);
      start = 1'b0; pause = 1'b0; clear = 1'b0; lap = 1'b0;
   endtask

   task automatic rd(input int addr);
      rd_en   = 1'b1;
      rd_addr = ADDR_W'(addr);
      @(negedge clk);
      rd_en   = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required completion");
      errors++;
      checks++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      cyc(2);
      $display("reset state");
      lit("rst state",     32'(state),      0);
      lit("rst unit",      32'(unit_count), 0);
      lit("rst lap_count", 32'(lap_count),  0);
      lit("rst rd_valid",  32'(rd_valid),   0);
      lit("rst rd_data",   32'(rd_data),    0);
      rst = 1'b0;

      $display("test 1: start timing");
      pulse(P_START);
      lit("t1 state", 32'(state), 1);
      cyc(12);
      lit("t1 unit", 32'(unit_count), 3);
      lit("t1 tick", 32'(tick), 1);

      $display("test 2: pause/resume");
      pulse(P_CLEAR);
      lit("t2 clear state", 32'(state), 0);
      pulse(P_START);
      cyc(8);
      lit("t2 unit2", 32'(unit_count), 2);
      cyc(1);
      pulse(P_PAUSE);
      lit("t2 paused", 32'(state), 2);
      cyc(20);
      lit("t2 hold unit", 32'(unit_count), 2);
      lit("t2 hold tick", 32'(tick), 0);
      pulse(P_START);
      lit("t2 resumed", 32'(state), 1);
      cyc(1);
      lit("t2 tick early", 32'(tick), 0);
      cyc(1);
      lit("t2 tick resume", 32'(tick), 1);
      lit("t2 unit resume", 32'(unit_count), 3);

      $display("test 3: lap fill");
      pulse(P_CLEAR);
      pulse(P_START);
      cyc(4);
      for (int k = 0; k < 5; k++) begin
         pulse(P_LAP);
         cyc(3);
      end
      lit("t3 lap_count", 32'(lap_count), 4);
      lit("t3 lap_full",  32'(lap_full), 1);
      lit("t3 lap_drop",  32'(lap_drop), 1);
      for (int a = 0; a < 4; a++) begin
         rd(a);
         lit("t3 rd_valid", 32'(rd_valid), 1);
         lit("t3 rd_data",  32'(rd_data), 32'(a + 1));
      end
      cyc(1);
      lit("t3 rd_valid idle", 32'(rd_valid), 0);
      lit("t3 rd_data hold",  32'(rd_data), 4);

      $display("test 4: lap/tick collision");
      pulse(P_CLEAR);
      pulse(P_START);
      cyc(27);
      lit("t4 unit before", 32'(unit_count), 6);
      pulse(P_LAP);
      lit("t4 unit after", 32'(unit_count), 7);
      lit("t4 lap_count",  32'(lap_count), 1);
      rd(0);
      lit("t4 stored", 32'(rd_data), 6);

      $display("test 5: overflow");
      pulse(P_CLEAR);
      pulse(P_START);
      cyc(4);
      pulse(P_LAP);
      cyc(59);
      lit("t5 unit wrap", 32'(unit_count), 0);
      lit("t5 overflow",  32'(overflow), 1);
      cyc(20);
      lit("t5 overflow sticky", 32'(overflow), 1);
      lit("t5 unit", 32'(unit_count), 5);
      pulse(P_CLEAR);
      lit("t5 clr overflow",  32'(overflow), 0);
      lit("t5 clr state",     32'(state), 0);
      lit("t5 clr lap_count", 32'(lap_count), 0);
      rd(0);
      lit("t5 rd_valid", 32'(rd_valid), 1);
      lit("t5 rd stale", 32'(rd_data), 0);

      $display("test 6: async reset mid-run");
      pulse(P_START);
      cyc(6);
      pulse(P_LAP);
      cyc(2);
      rd(0);
      lit("t6 rd before", 32'(rd_data), 1);
      #2 rst = 1'b1;
      #1;
      lit("t6 state",     32'(state), 0);
      lit("t6 unit",      32'(unit_count), 0);
      lit("t6 lap_count", 32'(lap_count), 0);
      lit("t6 rd_valid",  32'(rd_valid), 0);
      lit("t6 rd_data",   32'(rd_data), 0);
      lit("t6 tick",      32'(tick), 0);
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b1;
      clear = 1'b1;
      @(negedge clk);
      start = 1'b0;
      clear = 1'b0;
      lit("t6 start+clear", 32'(state), 0);
      cyc(5);
      lit("t6 idle state", 32'(state), 0);
      lit("t6 idle unit",  32'(unit_count), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/stopwatch_lap_recorder.md
Name: stopwatch_lap_recorder

Overview:
- Parametrised stopwatch: a prescaler divides clk down to a unit tick, and a unit counter accumulates ticks under IDLE/RUN/PAUSE control.
- A lap command captures the current unit count into an internal DEPTH-entry lap buffer.
- A registered read port lets the host or display logic retrieve recorded laps.
- Successor to the single-rate timer-with-memory block: adds a configurable rate, counter width, buffer depth, overflow/full flags and a read handshake.

Parameters:
- CLK_DIV, 50_000_000, clk cycles per unit tick (>=2).
- CNT_W, 8, unit counter and lap entry width.
- DEPTH, 8, lap buffer entries (power of two, >=2).
- ADDR_W, $clog2(DEPTH), lap address width (derived; not to be overridden).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  start/resume command, one-cycle pulse.
- pause  in  1  pause command, one-cycle pulse.
- clear  in  1  return to IDLE and zero the counters and flags, one-cycle pulse.
- lap  in  1  capture unit_count into the buffer, one-cycle pulse.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  lap index to read.
- rd_data  out  CNT_W  lap value, registered.
- rd_valid  out  1  rd_data valid, one cycle after rd_en.
- tick  out  1  one-cycle pulse on each unit increment.
- unit_count  out  CNT_W  elapsed units.
- state  out  2  0=IDLE, 1=RUN, 2=PAUSE.
- lap_count  out  ADDR_W+1  number of laps stored (0..DEPTH).
- lap_full  out  1  lap_count==DEPTH.
- lap_drop  out  1  sticky: a lap was rejected because the buffer was full.
- overflow  out  1  sticky: unit_count wrapped.

Behaviour:
- Reset (async, rst=1): state=IDLE; prescaler, unit_count and lap_count = 0; tick, rd_valid, rd_data, lap_drop and overflow = 0. Buffer contents are don't-care.
- All outputs are registered.
- Command priority within a cycle: clear > state-specific commands.
- clear, from any state: next cycle state=IDLE and prescaler, unit_count, lap_count, lap_drop, overflow and tick = 0. Buffer contents are retained but logically invalid.
- IDLE:
  - Prescaler and unit_count are held at 0.
  - start -> RUN next cycle. pause and lap are ignored.
- RUN:
  - Prescaler increments every cycle.
  - When prescaler==CLK_DIV-1: prescaler->0, tick=1 for the following cycle, unit_count+1.
  - When unit_count is all-ones at that point, it wraps to 0 and overflow is set.
  - pause -> PAUSE next cycle. start is ignored.
- PAUSE:
  - Prescaler and unit_count are frozen, keeping the partial prescaler value. tick=0.
  - start -> RUN; counting resumes from the frozen prescaler value.
  - pause and lap are ignored.
- Lap (RUN only):
  - Writes the current registered unit_count (the pre-increment value if a tick coincides) to entry lap_count; lap_count increments.
  - When lap_full: the write is suppressed, lap_count is unchanged and lap_drop is set.
  - lap together with pause in RUN: the lap is recorded and the transition to PAUSE is taken.
- Read:
  - rd_en in cycle N gives rd_valid=1 and rd_data in cycle N+1.
  - rd_addr >= lap_count returns rd_data=0 (rd_valid still 1).
  - A read of the entry being written in the same cycle returns the old contents (read-before-write).
  - rd_valid=0 when rd_en was 0; rd_data holds its last value.
  - Reads are legal in every state.
- Prescaler width: $clog2(CLK_DIV). Prescaler and counter compares are unsigned.

Decomposition:
- Package stopwatch_pkg: state encoding constants (ST_IDLE, ST_RUN, ST_PAUSE) and the 2-bit state type.
- One sub-module, lap_ram:
  - DEPTH x CNT_W storage.
  - One synchronous write port and one registered read port (read-before-write).
  - No reset on the storage array.
- The FSM, prescaler, counter and flags live in the top module.

Test Plan (CLK_DIV=4, CNT_W=4, DEPTH=4):
1. Start timing: rst pulse, then start -> state=1; tick pulses every 4 cycles; unit_count=3 after 12 cycles of RUN.
2. Pause/resume: pause 2 cycles after the unit 2 tick, hold 20 cycles -> unit_count stays 2 and tick=0; start -> next tick 2 cycles after resume, unit_count=3.
3. Lap fill: lap issued at units 1,2,3,4,5 -> lap_count=4, lap_full=1, lap_drop=1; reads of addr 0..3 -> rd_data 1,2,3,4, each with rd_valid one cycle after rd_en.
4. Lap/tick collision: lap issued in the cycle the prescaler is 3 with unit_count=6 -> stored value 6, unit_count becomes 7.
5. Overflow: run 16 ticks -> unit_count=0, overflow=1 and still 1 after 5 more ticks; clear -> overflow=0, state=0, lap_count=0, read addr 0 -> 0.
6. Reset mid-operation: assert rst asynchronously mid-RUN with laps stored -> all outputs zero immediately, state=IDLE; start+clear in the same cycle -> stays IDLE.
